// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for a 5-stage RV32I pipeline: stall/flush
// generation, E-stage forwarding selects, memory / mul-div wait FSM and stall counter.
module hazard_ctrl #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [4:0]           Rs1D,
  input  logic [4:0]           Rs2D,
  input  logic [4:0]           Rs1E,
  input  logic [4:0]           Rs2E,
  input  logic [4:0]           RdE,
  input  logic [4:0]           RdM,
  input  logic [4:0]           RdW,
  input  logic                 RegWriteM,
  input  logic                 RegWriteW,
  input  logic                 LoadE,
  input  logic                 PCSrcE,
  input  logic                 MemAccessM,
  input  logic                 mem_ack,
  input  logic                 MdStartE,
  input  logic                 md_done,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 StallE,
  output logic                 StallM,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic                 FlushM,
  output logic                 FlushW,
  output logic [1:0]           ForwardAE,
  output logic [1:0]           ForwardBE,
  output logic [CNT_WIDTH-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MD_WAIT  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_WIDTH-1:0]   r_stall_cycles;
  logic                   w_mem_frz;
  logic                   w_md_frz;
  logic                   w_lw_stall;

  // A pending memory access wins over a mul/div op; the mul/div freeze can
  // only start once the FSM is back in RUN.
  assign w_mem_frz  = MemAccessM & ~mem_ack & ((r_state == RUN) | (r_state == MEM_WAIT));
  assign w_md_frz   = MdStartE & ~md_done & ~w_mem_frz &
                      ((r_state == RUN) | (r_state == MD_WAIT));
  assign w_lw_stall = LoadE & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    w_state_nxt = r_state;
    StallF      = 1'b0;
    StallD      = 1'b0;
    StallE      = 1'b0;
    StallM      = 1'b0;
    FlushD      = 1'b0;
    FlushE      = 1'b0;
    FlushM      = 1'b0;
    FlushW      = 1'b0;

    case (r_state)
      RUN: begin
        if (w_mem_frz) begin
          w_state_nxt = MEM_WAIT;
        end else if (w_md_frz) begin
          w_state_nxt = MD_WAIT;
        end
      end
      MEM_WAIT: begin
        if (mem_ack) begin
          w_state_nxt = RUN;
        end
      end
      MD_WAIT: begin
        if (md_done) begin
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = RUN;
    endcase

    if (w_mem_frz) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (w_md_frz) begin
      // M keeps draining; a bubble enters M behind the frozen E stage.
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      FlushM = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (w_lw_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E)) begin
      ForwardAE = 2'b10;
    end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) begin
      ForwardAE = 2'b01;
    end
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E)) begin
      ForwardBE = 2'b10;
    end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) begin
      ForwardBE = 2'b01;
    end
  end

  // Saturating stall-cycle counter: holds at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_stall_cycles <= '0;
    end else if (StallF && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + CNT_ONE;
    end
  end

  assign stall_cycles = r_stall_cycles;

endmodule
